nx_interface_monitor_capture: RTL and testbench
===============================================

Name: nx_interface_monitor_capture

Overview:
- Downstream consumer of the interface-monitor pipe stage. Captures every beat that stage flags with im_vld into a DEPTH-entry ring buffer and exposes it through a pop-style read port for debug/CSR readout.
- Drives im_rdy back to the pipe stage, which throttles the monitored AXI4-S stream when the buffer is full in stall mode.
- Keeps saturating beat, frame and overwrite statistics.

Parameters:
- DEPTH, 64, number of capture entries; power of two, 4..1024.
- AW, $clog2(DEPTH), pointer width (derived; not overridable).
- CW, 32, width of the beat and frame statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- im_vld  in  1  beat qualifier from the monitor pipe stage.
- im_din  in  axi4s_dp_bus_t  beat being monitored (the pipe stage's pre-register bus); tvalid field ignored.
- cfg_en  in  1  capture enable.
- cfg_wrap  in  1  1 = overwrite oldest entry when full; 0 = stall via im_rdy.
- clr  in  1  synchronous clear of buffer and statistics.
- im_rdy  out  1  ready to the monitor pipe stage.
- rd_en  in  1  pop request.
- rd_vld  out  1  rd_data valid.
- rd_data  out  82  {tlast,tid,tstrb,tuser,tdata} of the popped entry.
- count  out  AW+1  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- beat_cnt  out  CW  beats captured, saturating.
- frame_cnt  out  CW  captured beats with tlast=1, saturating.
- ovr_cnt  out  16  entries overwritten in wrap mode, saturating.
- ovr_sticky  out  1  set on first overwrite; cleared only by clr or rst.

Behaviour:
- Reset: every output is 0 except im_rdy. im_rdy is combinational from registers and equals cfg_en after reset. wr_ptr, rd_ptr and count are 0.
- im_rdy = cfg_en & (cfg_wrap | ~full). full is derived from registered count only, so there is no path from im_vld to im_rdy.
- Write condition: wr = im_vld & im_rdy. When im_vld=1 and im_rdy=0, the beat is ignored. The pipe stage holds that beat upstream, so no overflow is recorded.
- Write action: on wr, mem[wr_ptr] <= im_din fields, then wr_ptr++ modulo DEPTH.
- Read condition: rd = rd_en & ~empty. rd_en while empty is ignored and rd_vld stays 0.
- Read action and latency: on rd, rd_data <= mem[rd_ptr] and rd_ptr++. rd_vld=1 on the following cycle. This is 1-cycle read latency with registered output; rd_data holds its value when rd_vld=0.
- Not full, wr only: count++.
- Not full, rd only: count--.
- Not full, wr and rd: count is unchanged.
- Empty, wr and rd_en in the same cycle: the write lands, the read is ignored, and there is no bypass.
- Full, stall mode (cfg_wrap=0): im_rdy=0, so no write can occur. rd frees one slot, and im_rdy rises the next cycle.
- Full, wrap mode, wr only: the oldest entry is overwritten and wr_ptr++. rd_ptr++ so that rd_ptr still marks the oldest valid entry. count stays DEPTH, ovr_cnt++ (saturating) and ovr_sticky <= 1.
- Full, wrap mode, wr and rd: rd_data returns the oldest entry, sampled before the write to the same slot. The write goes into the freed slot, rd_ptr++ once and wr_ptr++. count stays DEPTH and there is no overwrite.
- Statistics: on each wr, beat_cnt++. On each wr with tlast=1, frame_cnt++. All counters saturate at their all-ones value and never wrap.
- clr: clears pointers, count, statistics, ovr_sticky and rd_vld next cycle. clr takes priority over a wr or rd in the same cycle; those operations are discarded. Memory contents are not cleared.
- cfg_en=0: im_rdy=0 and the read side stays fully operational.
- cfg_wrap change: the new value takes effect on the next cycle's im_rdy and full decision. Changing it mid-operation never corrupts pointers.
- Reset mid-operation: asynchronous return to the reset state. A pending rd_vld is dropped.

Decomposition:
- cr_structs (shared): im_capture_entry_t, a packed struct {tlast,tid,tstrb,tuser,tdata} with width 82.
- cr_structs (shared): IM_CAP_OVR_W = 16.
- Sub-module: nx_im_capture_ram, a DEPTH x 82 flop array with one write port and one registered read port. It contains no pointer logic, so it can later be swapped for a RAM macro.
- Top level holds pointer and count control plus the statistics counters.

Test Plan:
- Fill, stall mode: DEPTH=4, cfg_en=1, cfg_wrap=0, 6 consecutive im_vld beats with tdata=1..6 -> 4 captured; full=1 and im_rdy=0 after the 4th; beats 5 and 6 ignored; beat_cnt=4, ovr_cnt=0.
- Drain: pop 4 with rd_en back-to-back -> rd_vld one cycle after each pop with tdata 1,2,3,4; empty=1; one further rd_en gives rd_vld=0.
- Wrap overwrite: DEPTH=4, cfg_wrap=1, 6 beats tdata=1..6 -> count=4, ovr_cnt=2, ovr_sticky=1; pops return 3,4,5,6.
- Simultaneous at full, wrap mode: buffer full holding 1..4, write tdata=9 with rd_en in the same cycle -> rd_data=1; count=4, ovr_cnt unchanged; subsequent pops return 2,3,4,9.
- Frames and saturation: 3 frames of 2 beats, tlast on the 2nd beat of each -> frame_cnt=3, beat_cnt=6. With CW forced to 4, 20 beats -> beat_cnt=15, held.
- clr and reset priority: clr asserted with im_vld and rd_en in the same cycle -> count=0, all statistics 0, rd_vld=0 next cycle. rst asserted mid-stream -> outputs 0 asynchronously; im_rdy=cfg_en.

Source files
------------

// File: rtl/nx_interface_monitor_capture_pkg.sv
// Shared types for the interface-monitor capture buffer: the monitored AXI4-S
// beat as seen at the pipe stage and the 82-bit entry stored per captured beat.
package nx_interface_monitor_capture_pkg;

  localparam int TDATA_W      = 64;
  localparam int TSTRB_W      = 8;
  localparam int TID_W        = 8;
  localparam int TUSER_W      = 1;
  localparam int IM_CAP_OVR_W = 16;

  typedef struct packed {
    logic               tvalid;
    logic               tlast;
    logic [TID_W-1:0]   tid;
    logic [TSTRB_W-1:0] tstrb;
    logic [TUSER_W-1:0] tuser;
    logic [TDATA_W-1:0] tdata;
  } axi4s_dp_bus_t;

  // Field order is the readout order {tlast,tid,tstrb,tuser,tdata}, 82 bits.
  typedef struct packed {
    logic               tlast;
    logic [TID_W-1:0]   tid;
    logic [TSTRB_W-1:0] tstrb;
    logic [TUSER_W-1:0] tuser;
    logic [TDATA_W-1:0] tdata;
  } im_capture_entry_t;

  localparam int IM_CAP_ENTRY_W = $bits(im_capture_entry_t);

endpackage

// File: rtl/nx_interface_monitor_capture_if.sv
// Capture-side bus: monitored beat handshake toward the pipe stage plus the
// pop-style readout port.
interface nx_interface_monitor_capture_if;
  import nx_interface_monitor_capture_pkg::*;

  // Handshakes: a beat transfers on a cycle where im_vld & im_rdy; im_rdy never
  // depends on im_vld. A pop is accepted on rd_en while non-empty and its data
  // appears with rd_vld one cycle later; rd_data holds while rd_vld is low.
  logic              im_vld;
  axi4s_dp_bus_t     im_din;
  logic              im_rdy;
  logic              rd_en;
  logic              rd_vld;
  im_capture_entry_t rd_data;

  modport master (
    output im_vld, im_din, rd_en,
    input  im_rdy, rd_vld, rd_data
  );

  modport slave (
    input  im_vld, im_din, rd_en,
    output im_rdy, rd_vld, rd_data
  );

endinterface

// File: rtl/nx_im_capture_ram.sv
// DEPTH x 82 capture storage: one write port, one registered read port, no
// pointer logic so it can be replaced by a RAM macro.
module nx_im_capture_ram
  import nx_interface_monitor_capture_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  im_capture_entry_t wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output im_capture_entry_t rdata
);

  im_capture_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read samples the pre-write contents when raddr == waddr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/nx_interface_monitor_capture.sv
// Interface-monitor capture: ring buffer of flagged beats with stall or
// overwrite-on-full policy, pop readout and saturating statistics.
module nx_interface_monitor_capture
  import nx_interface_monitor_capture_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int CW    = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  nx_interface_monitor_capture_if.slave bus,
  input  logic                     cfg_en,
  input  logic                     cfg_wrap,
  input  logic                     clr,
  output logic [AW:0]              count,
  output logic                     empty,
  output logic                     full,
  output logic [CW-1:0]            beat_cnt,
  output logic [CW-1:0]            frame_cnt,
  output logic [IM_CAP_OVR_W-1:0]  ovr_cnt,
  output logic                     ovr_sticky
);

  localparam logic [AW:0]             DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]             CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]           PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]           STAT_ONE  = CW'(1);
  localparam logic [IM_CAP_OVR_W-1:0] OVR_ONE   = IM_CAP_OVR_W'(1);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_vld_q;
  logic              im_rdy;
  logic              wr;
  logic              rd;
  im_capture_entry_t wr_entry;
  im_capture_entry_t rd_q;
  logic              unused_tvalid;

  assign unused_tvalid = bus.im_din.tvalid;

  // Status comes only from registered count, keeping im_vld out of im_rdy.
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_CNT);
  assign im_rdy = cfg_en & (cfg_wrap | ~full);

  // clr wins over any same-cycle transfer.
  assign wr = bus.im_vld & im_rdy & ~clr;
  assign rd = bus.rd_en & ~empty & ~clr;

  always_comb begin
    wr_entry       = '0;
    wr_entry.tlast = bus.im_din.tlast;
    wr_entry.tid   = bus.im_din.tid;
    wr_entry.tstrb = bus.im_din.tstrb;
    wr_entry.tuser = bus.im_din.tuser;
    wr_entry.tdata = bus.im_din.tdata;
  end

  nx_im_capture_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (rd),
    .raddr (rd_ptr),
    .rdata (rd_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_vld_q   <= 1'b0;
      beat_cnt   <= '0;
      frame_cnt  <= '0;
      ovr_cnt    <= '0;
      ovr_sticky <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_vld_q   <= 1'b0;
      beat_cnt   <= '0;
      frame_cnt  <= '0;
      ovr_cnt    <= '0;
      ovr_sticky <= 1'b0;
    end else begin
      rd_vld_q <= rd;
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // A write into a full buffer consumes the oldest slot, read or not.
      if (rd || (wr && full)) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr && !rd && !full) begin
        count <= count + CNT_ONE;
      end else if (rd && !wr) begin
        count <= count - CNT_ONE;
      end
      if (wr && full && !rd) begin
        ovr_sticky <= 1'b1;
        if (ovr_cnt != '1) begin
          ovr_cnt <= ovr_cnt + OVR_ONE;
        end
      end
      if (wr && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + STAT_ONE;
      end
      if (wr && wr_entry.tlast && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + STAT_ONE;
      end
    end
  end

  assign bus.im_rdy  = im_rdy;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_nx_interface_monitor_capture.sv
// Bench for nx_interface_monitor_capture: directed vectors, expected pop data
// queued at pop time and checked by an independent monitor on rd_vld.
module tb_nx_interface_monitor_capture;
  import nx_interface_monitor_capture_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic cfg_en, cfg_wrap, clr;
  logic [AW:0] count;
  logic empty, full, ovr_sticky;
  logic [31:0] beat_cnt, frame_cnt;
  logic [IM_CAP_OVR_W-1:0] ovr_cnt;

  logic cfg_en_s;
  logic [AW:0] count_s;
  logic empty_s, full_s, ovr_sticky_s;
  logic [3:0] beat_cnt_s, frame_cnt_s;
  logic [IM_CAP_OVR_W-1:0] ovr_cnt_s;

  nx_interface_monitor_capture_if bus ();
  nx_interface_monitor_capture_if bus_s ();

  nx_interface_monitor_capture #(.DEPTH(DEPTH), .CW(32)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_en(cfg_en), .cfg_wrap(cfg_wrap), .clr(clr),
    .count(count), .empty(empty), .full(full),
    .beat_cnt(beat_cnt), .frame_cnt(frame_cnt),
    .ovr_cnt(ovr_cnt), .ovr_sticky(ovr_sticky)
  );

  nx_interface_monitor_capture #(.DEPTH(DEPTH), .CW(4)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_s),
    .cfg_en(cfg_en_s), .cfg_wrap(1'b1), .clr(1'b0),
    .count(count_s), .empty(empty_s), .full(full_s),
    .beat_cnt(beat_cnt_s), .frame_cnt(frame_cnt_s),
    .ovr_cnt(ovr_cnt_s), .ovr_sticky(ovr_sticky_s)
  );

  // ---------------- scoreboard ----------------
  logic [IM_CAP_ENTRY_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic axi4s_dp_bus_t mk_beat(input logic [63:0] v, input logic last);
    axi4s_dp_bus_t b;
    b.tvalid = 1'b1;
    b.tlast  = last;
    b.tid    = v[7:0] ^ 8'h5a;
    b.tstrb  = 8'hff;
    b.tuser  = v[0];
    b.tdata  = v;
    return b;
  endfunction

  // Expected entry layout {tlast,tid,tstrb,tuser,tdata} for a beat from mk_beat.
  function automatic logic [IM_CAP_ENTRY_W-1:0] mk_exp(input logic [63:0] v, input logic last);
    logic [7:0] id;
    id = v[7:0] ^ 8'h5a;
    return {last, id, 8'hff, v[0], v};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_vld=1 tdata=%0d expected no pop", bus.rd_data.tdata);
      end else begin
        logic [IM_CAP_ENTRY_W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", bus.rd_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beats(input int first, input int n, input int last_every);
    for (int i = 0; i < n; i++) begin
      bus.im_vld = 1'b1;
      bus.im_din = mk_beat(64'(first + i), (last_every != 0) && ((i % last_every) == last_every - 1));
      tick();
    end
    bus.im_vld = 1'b0;
  endtask

  task automatic pop_seq(input int vals[4]);
    for (int i = 0; i < 4; i++) begin
      bus.rd_en = 1'b1;
      exp_q.push_back(mk_exp(64'(vals[i]), 1'b0));
      tick();
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    cfg_en = 1'b1; cfg_wrap = 1'b0; clr = 1'b0; cfg_en_s = 1'b1;
    bus.im_vld = 1'b0; bus.im_din = '0; bus.rd_en = 1'b0;
    bus_s.im_vld = 1'b0; bus_s.im_din = '0; bus_s.rd_en = 1'b0;
    repeat (2) tick();

    check("rst_count", 64'(count), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full", 64'(full), 0);
    check("rst_beat", 64'(beat_cnt), 0);
    check("rst_sticky", 64'(ovr_sticky), 0);
    check("rst_rd_vld", 64'(bus.rd_vld), 0);
    check("rst_rd_data", 64'(bus.rd_data.tdata), 0);
    check("rst_im_rdy", 64'(bus.im_rdy), 1);
    cfg_en = 1'b0; #1;
    check("im_rdy_cfg_en0", 64'(bus.im_rdy), 0);
    cfg_en = 1'b1;
    rst = 1'b0;
    tick();

    // Fill in stall mode: beats 5 and 6 are held off by im_rdy.
    drive_beats(1, 6, 0);
    check("stall_count", 64'(count), 4);
    check("stall_full", 64'(full), 1);
    check("stall_im_rdy", 64'(bus.im_rdy), 0);
    check("stall_beat", 64'(beat_cnt), 4);
    check("stall_ovr", 64'(ovr_cnt), 0);

    // Drain; first pop frees a slot so im_rdy returns the next cycle.
    bus.rd_en = 1'b1;
    exp_q.push_back(mk_exp(64'd1, 1'b0));
    tick();
    check("drain_im_rdy", 64'(bus.im_rdy), 1);
    for (int v = 2; v <= 4; v++) begin
      exp_q.push_back(mk_exp(64'(v), 1'b0));
      tick();
    end
    bus.rd_en = 1'b0;
    tick();
    check("drain_empty", 64'(empty), 1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("pop_empty_rd_vld", 64'(bus.rd_vld), 0);

    // Wrap mode overwrite.
    clr = 1'b1; tick(); clr = 1'b0;
    cfg_wrap = 1'b1;
    drive_beats(1, 6, 0);
    check("wrap_count", 64'(count), 4);
    check("wrap_ovr", 64'(ovr_cnt), 2);
    check("wrap_sticky", 64'(ovr_sticky), 1);
    check("wrap_beat", 64'(beat_cnt), 6);
    pop_seq('{3, 4, 5, 6});
    check("wrap_empty", 64'(empty), 1);

    // Empty buffer: simultaneous write and pop, pop ignored without bypass.
    bus.im_vld = 1'b1; bus.im_din = mk_beat(64'd7, 1'b0); bus.rd_en = 1'b1;
    tick();
    bus.im_vld = 1'b0; bus.rd_en = 1'b0;
    check("empty_wr_rd_count", 64'(count), 1);
    check("empty_wr_rd_vld", 64'(bus.rd_vld), 0);
    bus.rd_en = 1'b1; exp_q.push_back(mk_exp(64'd7, 1'b0)); tick();
    bus.rd_en = 1'b0; tick();

    // Full in wrap mode: write 9 and pop together.
    drive_beats(1, 4, 0);
    bus.im_vld = 1'b1; bus.im_din = mk_beat(64'd9, 1'b0); bus.rd_en = 1'b1;
    exp_q.push_back(mk_exp(64'd1, 1'b0));
    tick();
    bus.im_vld = 1'b0; bus.rd_en = 1'b0;
    check("simul_count", 64'(count), 4);
    check("simul_ovr", 64'(ovr_cnt), 2);
    tick();
    pop_seq('{2, 3, 4, 9});

    // clr beats a same-cycle write and pop.
    drive_beats(10, 2, 0);
    clr = 1'b1; bus.im_vld = 1'b1; bus.im_din = mk_beat(64'd12, 1'b1); bus.rd_en = 1'b1;
    tick();
    clr = 1'b0; bus.im_vld = 1'b0; bus.rd_en = 1'b0;
    check("clr_count", 64'(count), 0);
    check("clr_beat", 64'(beat_cnt), 0);
    check("clr_frame", 64'(frame_cnt), 0);
    check("clr_ovr", 64'(ovr_cnt), 0);
    check("clr_sticky", 64'(ovr_sticky), 0);
    check("clr_rd_vld", 64'(bus.rd_vld), 0);

    // Frames: tlast on every second beat.
    drive_beats(30, 6, 2);
    check("frame_cnt", 64'(frame_cnt), 3);
    check("frame_beat", 64'(beat_cnt), 6);
    clr = 1'b1; tick(); clr = 1'b0;
    cfg_wrap = 1'b0;

    // Reset mid-stream drops the pending rd_vld.
    drive_beats(20, 2, 0);
    bus.im_vld = 1'b1; bus.im_din = mk_beat(64'd22, 1'b0); bus.rd_en = 1'b1;
    tick();
    rst = 1'b1; #1;
    check("mid_rst_rd_vld", 64'(bus.rd_vld), 0);
    check("mid_rst_rd_data", 64'(bus.rd_data.tdata), 0);
    check("mid_rst_count", 64'(count), 0);
    check("mid_rst_beat", 64'(beat_cnt), 0);
    check("mid_rst_im_rdy", 64'(bus.im_rdy), 1);
    bus.im_vld = 1'b0; bus.rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Saturation on the CW=4 instance.
    for (int i = 0; i < 20; i++) begin
      bus_s.im_vld = 1'b1;
      bus_s.im_din = mk_beat(64'(100 + i), 1'b1);
      tick();
    end
    check("sat_beat", 64'(beat_cnt_s), 15);
    check("sat_frame", 64'(frame_cnt_s), 15);
    check("sat_ovr", 64'(ovr_cnt_s), 16);
    tick();
    bus_s.im_vld = 1'b0;
    check("sat_beat_held", 64'(beat_cnt_s), 15);

    repeat (3) tick();
    check("exp_q_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
